// File: rtl/sprite_engine.sv
// sprite_engine: NUM_SPRITES-way sprite overlay with a 3-stage pipeline,
// double-buffered positions and synchronous-ROM fetch.
// Ports: clk, rst_n (async low); pix_valid/pixelx/pixely pixel in;
//   frame_start commits shadow positions; pos_wr/pos_sel/pos_x/pos_y/pos_en
//   shadow write; rom_addr/rom_color ROM port (1-cycle latency);
//   out_valid/visible/sprite_id/RGB result 3 cycles after the pixel;
//   collision per-sprite overlap flags of the previous frame.
// Optional: define SPRITE_COLLISION_EN to build collision tracking,
//   otherwise collision is tied to 0.
module sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 64,
  parameter int SPRITE_H    = 64,
  parameter int COLOR_W     = 3,
  parameter int ADDR_W      = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic [9:0]                    pixelx,
  input  logic [9:0]                    pixely,
  input  logic                          frame_start,
  input  logic                          pos_wr,
  input  logic [2:0]                    pos_sel,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          pos_en,
  output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPRITES*COLOR_W-1:0] rom_color,
  output logic                          out_valid,
  output logic                          visible,
  output logic [2:0]                    sprite_id,
  output logic [23:0]                   RGB,
  output logic [NUM_SPRITES-1:0]        collision
);

  localparam int N = NUM_SPRITES;

  logic [9:0]   sh_x [N];
  logic [9:0]   sh_y [N];
  logic [N-1:0] sh_en;
  logic [9:0]   ac_x [N];
  logic [9:0]   ac_y [N];
  logic [N-1:0] ac_en;

  // Shadow bank; selects beyond N match no slot and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en <= '0;
      for (int i = 0; i < N; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
    end else if (pos_wr) begin
      for (int i = 0; i < N; i++) begin
        if (pos_sel == 3'(i)) begin
          sh_x[i]  <= pos_x;
          sh_y[i]  <= pos_y;
          sh_en[i] <= pos_en;
        end
      end
    end
  end

  // Active bank samples the pre-write shadow on a coincident pos_wr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_en <= '0;
      for (int i = 0; i < N; i++) begin
        ac_x[i] <= '0;
        ac_y[i] <= '0;
      end
    end else if (frame_start) begin
      ac_en <= sh_en;
      for (int i = 0; i < N; i++) begin
        ac_x[i] <= sh_x[i];
        ac_y[i] <= sh_y[i];
      end
    end
  end

  logic [N-1:0]        hit;
  logic [N*ADDR_W-1:0] addr_d;

  // 11-bit compares so x+W past 1023 cannot wrap back on screen.
  always_comb begin
    logic [10:0] px, py, x0, y0, dx, dy;
    hit    = '0;
    addr_d = '0;
    px     = {1'b0, pixelx};
    py     = {1'b0, pixely};
    x0     = '0;
    y0     = '0;
    dx     = '0;
    dy     = '0;
    for (int i = 0; i < N; i++) begin
      x0 = {1'b0, ac_x[i]};
      y0 = {1'b0, ac_y[i]};
      dx = px - x0;
      dy = py - y0;
      if (ac_en[i] && pix_valid &&
          px >= x0 && px < x0 + 11'(SPRITE_W) &&
          py >= y0 && py < y0 + 11'(SPRITE_H)) begin
        hit[i] = 1'b1;
        addr_d[i*ADDR_W +: ADDR_W] =
          ADDR_W'(32'(dy) * SPRITE_W + 32'(dx));
      end
    end
  end

  logic [N-1:0] s1_hit, s2_hit;
  logic         s1_valid, s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit   <= '0;
      s1_valid <= 1'b0;
      rom_addr <= '0;
      s2_hit   <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_hit   <= hit;
      s1_valid <= pix_valid;
      rom_addr <= addr_d;
      s2_hit   <= s1_hit;
      s2_valid <= s1_valid;
    end
  end

  logic [N-1:0]       opq;
  logic [2:0]         win_id;
  logic [COLOR_W-1:0] win_col;

  // Scan high to low so the lowest opaque index is written last.
  always_comb begin
    opq     = '0;
    win_id  = '0;
    win_col = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (s2_hit[i] && rom_color[i*COLOR_W +: COLOR_W] != '0) begin
        opq[i]  = 1'b1;
        win_id  = 3'(i);
        win_col = rom_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  function automatic logic [23:0] pal(input logic [2:0] c);
    case (c)
      3'd1:    pal = 24'hFF0000;
      3'd2:    pal = 24'h00FF00;
      3'd3:    pal = 24'h0000FF;
      3'd4:    pal = 24'hFFFF00;
      3'd5:    pal = 24'hFFFFFF;
      3'd7:    pal = 24'h808080;
      default: pal = 24'h000000;
    endcase
  endfunction

  logic any;
  assign any = s2_valid && (opq != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      visible   <= 1'b0;
      sprite_id <= '0;
      RGB       <= '0;
    end else begin
      out_valid <= s2_valid;
      visible   <= any;
      sprite_id <= any ? win_id : 3'd0;
      RGB       <= any ? pal(win_col[2:0]) : 24'h0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [N-1:0] sticky, cur;

  // Only pixels with two or more opaque sprites mark anyone.
  assign cur = (s2_valid && ((opq & (opq - 1'b1)) != '0)) ? opq : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky    <= '0;
      collision <= '0;
    end else if (frame_start) begin
      collision <= sticky | cur;
      sticky    <= '0;
    end else begin
      sticky <= sticky | cur;
    end
  end
`else
  assign collision = '0;
`endif

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised multi-sprite overlay for the VGA controller. Generalises the single-sprite printer to NUM_SPRITES independent sprites.
- Adds frame-synchronous double-buffered positions, per-sprite enable, transparency, fixed priority and a pipelined synchronous-ROM interface.
- Sits between the VGA timing generator (pixel coordinates) and the RGB mux; sprite bitmaps live in external synchronous ROMs, one per sprite.

Parameters:
- NUM_SPRITES, 4, number of sprites (1..8); index 0 has highest priority.
- SPRITE_W, 64, sprite width in pixels.
- SPRITE_H, 64, sprite height in pixels.
- COLOR_W, 3, ROM color index width; index 0 is transparent.
- ADDR_W, $clog2(SPRITE_W*SPRITE_H), ROM address width per sprite.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixelx/pixely valid this cycle (active video).
- pixelx  in  10  current pixel x.
- pixely  in  10  current pixel y.
- frame_start  in  1  one-cycle pulse at start of vertical blanking; commits shadow registers.
- pos_wr  in  1  shadow write strobe; always accepted.
- pos_sel  in  3  sprite index written.
- pos_x  in  10  new x for the selected sprite.
- pos_y  in  10  new y for the selected sprite.
- pos_en  in  1  new enable for the selected sprite.
- rom_addr  out  NUM_SPRITES*ADDR_W  packed ROM addresses; sprite i at [i*ADDR_W +: ADDR_W].
- rom_color  in  NUM_SPRITES*COLOR_W  packed ROM data; 1-cycle synchronous latency after rom_addr.
- out_valid  out  1  pixel result valid.
- visible  out  1  an opaque sprite pixel covers this pixel.
- sprite_id  out  3  index of the winning sprite.
- RGB  out  24  winning color.
- collision  out  NUM_SPRITES  per-sprite collision flags of the previous frame.

Behaviour:
- Reset: all shadow and active positions = 0, all enables = 0. rom_addr = 0, out_valid = 0, visible = 0, sprite_id = 0, RGB = 0, collision = 0. Pipeline valid bits are cleared.
- Reset is asynchronous. Asserting it mid-frame drops all in-flight pixels and produces no partial outputs.
- Shadow writes:
  - On pos_wr, shadow[pos_sel] <= {pos_x, pos_y, pos_en}.
  - A pos_sel >= NUM_SPRITES is ignored.
  - Multiple writes before a commit: the last one wins.
- Commit:
  - On frame_start, active <= shadow for all sprites in the same cycle.
  - pos_wr coincident with frame_start: active takes the old shadow value; the new value lands in shadow and commits at the next frame_start.
- Hit test, per sprite i, 11-bit arithmetic with no wrap:
  - hit_i = en_i & pix_valid & pixelx >= x_i & pixelx < x_i+SPRITE_W & pixely >= y_i & pixely < y_i+SPRITE_H.
  - A sprite extending past 639/479 is clipped, never wrapped.
- ROM address: (pixely-y_i)*SPRITE_W + (pixelx-x_i) when hit_i, else 0.
- Pipeline, pixel presented in cycle t:
  - Edge ending t: register hit vector, valid and rom_addr (rom_addr visible in t+1).
  - Next edge: ROM returns rom_color (visible in t+2); hit and valid are delayed alongside it.
  - Next edge: register outputs. out_valid/visible/sprite_id/RGB correspond to pixel t in cycle t+3.
  - Fully pipelined: one pixel per clock, no stalls.
- Opacity and priority:
  - opaque_i = hit_i & rom_color_i != 0.
  - Winner = lowest index with opaque_i. A transparent pixel of a higher-priority sprite exposes lower sprites.
  - visible = any opaque_i. With no winner, sprite_id = 0 and RGB = 0.
- Palette (color index to RGB):
  - 1 = FF0000, 2 = 00FF00, 3 = 0000FF, 4 = FFFF00, 5 = FFFFFF, 6 = 000000, 7 = 808080.
  - For COLOR_W > 3, only the low 3 bits are used.
- out_valid = delayed pix_valid. When out_valid = 0, visible = 0.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- With the macro defined:
  - An internal sticky vector sets bit i whenever opaque_i and at least one other opaque_j occur at the same valid pixel, evaluated at the output stage.
  - On frame_start: collision <= sticky | current-cycle hits, then sticky clears.
  - The collision output holds until the next frame_start.
- Without the macro: no collision logic is built and collision is tied to 0. The port list is unchanged.

Test Plan:
- Reset: hold rst_n = 0 with pix_valid toggling, then release -> all outputs 0. First out_valid occurs exactly 3 cycles after the first pix_valid.
- Single sprite (W = H = 64): write sprite 0 to (100,50) with en = 1, pulse frame_start, ROM returns 5.
  - Pixel (100,50) -> rom_addr[0] = 0, then visible = 1, RGB = FFFFFF at t+3.
  - Pixel (163,113) -> addr 4095.
  - Pixel (164,50) and pixel (99,50) -> visible = 0.
- Commit timing: pos_wr to (200,200) without frame_start -> sprite still drawn at (100,50). After frame_start -> drawn at (200,200). pos_wr coincident with frame_start -> takes effect one frame later.
- Priority/transparency: sprites 0 and 1 both at (10,10). sprite0 color 1, sprite1 color 3 -> RGB = FF0000, sprite_id = 0. sprite0 color 0 -> RGB = 0000FF, sprite_id = 1.
- Clipping: sprite at (600,450), pixel (639,479) -> visible, addr 29*64+39 = 1895. No hit at pixel (0,0).
- Collision (macro on): sprites 0 and 2 opaque-overlap at one pixel -> after frame_start collision = 0b0101. Next frame with no overlap -> after frame_start collision = 0. Macro off -> always 0.
